// File: rtl/tff_seq_ctrl_pkg.sv
// Shared encodings for the T flip-flop bank sequencer.
// Imported by the controller and the testbench.
package tff_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/tff_seq_ctrl_if.sv
// Command/status bundle between a command source and the sequencer.
interface tff_seq_ctrl_if #(parameter int WIDTH = 4);
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic             pause;
  logic [WIDTH-1:0] t_en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (output start, dir, limit, pause, input t_en, count, busy, done);
  modport slave  (input start, dir, limit, pause, output t_en, count, busy, done);
endinterface

// File: rtl/tff_seq_ctrl_cell.sv
// One T flip-flop cell with synchronous load; priority is rst, ld, t.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q,
  output logic qb
);
  logic q_q, qb_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q  <= 1'b0;
      qb_q <= 1'b1;
    end else if (ld) begin
      q_q  <= d;
      qb_q <= ~d;
    end else if (t) begin
      q_q  <= ~q_q;
      qb_q <= ~qb_q;
    end
  end

  assign q  = q_q;
  assign qb = qb_q;
endmodule

// File: rtl/tff_seq_ctrl.sv
// Sequencer: latches a run command, loads the T-cell bank and emits
// per-bit toggle enables until the end value is reached, then pulses done.
module tff_seq_ctrl
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  tff_seq_ctrl_if.slave  bus
);
  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] cnt, cnt_b;
  logic [WIDTH-1:0] step, t_en, ld_val;
  logic             ld, at_end;

  tff_cell u_cell [WIDTH-1:0] (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .d   (ld_val),
    .t   (t_en),
    .q   (cnt),
    .qb  (cnt_b)
  );

  // Carry/borrow chain: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic up_c, dn_c;
    step = '0;
    up_c = 1'b1;
    dn_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step[i] = (dir_q == DIR_DN) ? dn_c : up_c;
      up_c    = up_c & cnt[i];
      dn_c    = dn_c & cnt_b[i];
    end
  end

  // Terminal check comes before stepping, so the bank can never wrap.
  assign at_end = (dir_q == DIR_UP) ? (cnt == lim_q) : (cnt == '0);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lim_d   = lim_q;
    ld      = 1'b0;
    ld_val  = '0;
    t_en    = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          dir_d   = bus.dir;
          lim_d   = bus.limit;
          ld      = 1'b1;
          ld_val  = (bus.dir == DIR_DN) ? bus.limit : '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (at_end)          state_d = ST_DONE;
        else if (!bus.pause) t_en    = step;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      lim_q   <= lim_d;
    end
  end

  assign bus.t_en  = t_en;
  assign bus.count = cnt;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Directed scoreboard bench: stimulus queues per-cycle expectations, a
// negedge monitor pops and compares them against the live outputs.
module tb_tff_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tff_seq_ctrl_if #(.WIDTH(4)) bus();

  tff_seq_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [3:0] c;
    logic [3:0] t;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;

  function automatic void chk(input string n, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s @%0t: got %h want %h", n, $time, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("count", bus.count, e.c);
      chk("t_en", bus.t_en, e.t);
      chk("busy", {3'b0, bus.busy}, {3'b0, e.b});
      chk("done", {3'b0, bus.done}, {3'b0, e.d});
    end
  end

  // After an edge: expect this cycle's outputs, then drive inputs for the next edge.
  task automatic cyc(input logic r, input logic s, input logic dr, input logic [3:0] lm,
                     input logic p, input logic [3:0] ec, input logic [3:0] et,
                     input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    bus.start = s;
    bus.dir   = dr;
    bus.limit = lm;
    bus.pause = p;
    e = '{c: ec, t: et, b: eb, d: ed};
    sb.push_back(e);
  endtask

  initial begin
    logic [3:0] et;
    rst = 1'b0; bus.start = 1'b1; bus.dir = 1'b0; bus.limit = 4'd7; bus.pause = 1'b0;
    // reset with start held high
    cyc(0,1,0,7,0, 0,0,0,0);
    cyc(1,1,0,5,0, 0,0,0,0);
    // up to 5
    cyc(1,0,0,0,0, 0,4'b0001,1,0);
    cyc(1,0,0,0,0, 1,4'b0011,1,0);
    cyc(1,0,0,0,0, 2,4'b0001,1,0);
    cyc(1,0,0,0,0, 3,4'b0111,1,0);
    cyc(1,0,0,0,0, 4,4'b0001,1,0);
    cyc(1,0,0,0,0, 5,4'b0000,1,0);
    cyc(1,0,0,0,0, 5,4'b0000,0,1);
    // IDLE, then down from 4 with a 2-cycle pause at 2
    cyc(1,1,1,4,0, 5,0,0,0);
    cyc(1,0,0,0,0, 4,4'b0111,1,0);
    cyc(1,0,0,0,0, 3,4'b0001,1,0);
    cyc(1,0,0,0,1, 2,4'b0000,1,0);
    cyc(1,0,0,0,1, 2,4'b0000,1,0);
    cyc(1,0,0,0,0, 2,4'b0011,1,0);
    cyc(1,0,0,0,0, 1,4'b0001,1,0);
    cyc(1,0,0,0,0, 0,4'b0000,1,0);
    cyc(1,0,0,0,0, 0,4'b0000,0,1);
    // limit = 0
    cyc(1,1,0,0,0, 0,0,0,0);
    cyc(1,0,0,0,0, 0,0,1,0);
    cyc(1,0,0,0,0, 0,0,0,1);
    // full-range up to 15; start/dir/limit wiggled mid-run must be ignored
    cyc(1,1,0,15,0, 0,0,0,0);
    for (int v = 0; v < 16; v++) begin
      et = (v == 15) ? 4'h0 : 4'(v ^ (v + 1));
      cyc(1, (v >= 3 && v <= 10), (v >= 3 && v <= 10), 4'd3, 0, 4'(v), et, 1, 0);
    end
    // restart from DONE with limit 2, no IDLE cycle
    cyc(1,1,0,2,0, 15,0,0,1);
    cyc(1,0,0,0,0, 0,4'b0001,1,0);
    cyc(1,0,0,0,0, 1,4'b0011,1,0);
    cyc(1,0,0,0,0, 2,4'b0000,1,0);
    cyc(1,0,0,0,0, 2,4'b0000,0,1);
    // abort: up to 9, reset at count 3
    cyc(1,1,0,9,0, 2,0,0,0);
    cyc(1,0,0,0,0, 0,4'b0001,1,0);
    cyc(1,0,0,0,0, 1,4'b0011,1,0);
    cyc(1,0,0,0,0, 2,4'b0001,1,0);
    cyc(0,0,0,0,0, 3,4'b0111,1,0);
    cyc(1,0,0,0,0, 0,0,0,0);
    cyc(1,0,0,0,0, 0,0,0,0);
    cyc(1,0,0,0,0, 0,0,0,0);
    cyc(1,0,0,0,0, 0,0,0,0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/tff_seq_ctrl.md
Name: tff_seq_ctrl

Overview:
Sequencer for a bank of T flip-flop cells forming a WIDTH-bit counter.
- Accepts a start command with a limit and a direction.
- Computes the per-bit toggle enables and steps the bank once per un-paused cycle until the end value is reached.
- Then pulses done.
- Sits between a command source (testbench or higher-level FSM) and the T flip-flop datapath.
- Exposes the toggle vector so the bank's behaviour can be checked bit by bit.

Parameters:
WIDTH, 4, number of T flip-flop cells in the bank (count/limit width), 1 to 16

Ports:
clk  input  1  clock; all state changes on posedge clk
rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
start  input  1  command strobe; sampled in IDLE or DONE only
dir  input  1  direction, latched with start: 0 = up (0 to limit), 1 = down (limit to 0)
limit  input  WIDTH  end value (up) or start value (down), latched with start
pause  input  1  when 1 in RUN, freezes the bank (all toggles 0)
t_en  output  WIDTH  toggle enable driven to each T cell this cycle
count  output  WIDTH  current bank state (Q of cells, bit i = cell i)
busy  output  1  1 while in RUN
done  output  1  one-cycle pulse on completion

Behaviour:
- States: IDLE, RUN, DONE (2-bit encoding).
- Reset (rst=0 at posedge): state=IDLE, count=0, latched dir=0, latched limit=0, busy=0, done=0, t_en=0. Reset has priority over every other input.
- Reset during RUN aborts the run with no done pulse.

IDLE:
- t_en=0.
- start=1 latches dir and limit, synchronously loads the bank, and goes to RUN.
- Bank load value: up loads 0, down loads limit.
- The load is a cell load, not a toggle.

RUN (busy=1):
- End value: up = latched limit, down = 0.
- If count == end value: t_en=0, next state DONE.
- Else if pause=1: t_en=0, stay in RUN.
- Else up: t_en[0]=1, t_en[i]=&count[i-1:0]. Count increments by 1 at the next edge.
- Else down: t_en[0]=1, t_en[i]=&(~count[i-1:0]). Count decrements by 1 at the next edge.
- t_en is combinational from state, count, latched dir and pause. The cells apply it at the next edge.
- start, dir and limit are ignored in RUN. Latched values are not disturbed.

DONE:
- done=1 and busy=0 for exactly one cycle; count holds its end value.
- start=1 in DONE restarts immediately: latches new dir/limit, loads the bank, goes to RUN.
- Otherwise the next state is IDLE.

Latency and boundaries:
- Un-paused run latency: for a run of L steps (up: L = limit; down: L = limit), done is high in the cycle after edge L+1, counting the start-sampling edge as edge 0.
- limit=0: RUN for one cycle with t_en=0, then DONE.
- Each paused cycle adds exactly one cycle of latency.
- Count never wraps during a run, because termination is checked before stepping.
- limit = 2^WIDTH-1 up: terminates at all-ones, with no wrap to 0.
- count holds its last value in IDLE until the next start or reset.

Decomposition:
- Package tff_seq_pkg: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and direction constants (DIR_UP=1'b0, DIR_DN=1'b1).
- Sub-module tff_cell, instantiated WIDTH times, with ports clk, rst (sync active-low, clears q to 0, qb to 1), ld, d, t, q, qb.
- tff_cell priority: rst, then ld (q=d, qb=~d), then t (toggle q and qb), else hold.
- Controller contains the FSM, limit/dir latches, terminal compare and t_en generation.

Test Plan:
- Reset: rst=0 for 2 edges with start=1 → count=0, busy=0, done=0, t_en=0; start is ignored while rst=0.
- Up count: start with dir=0, limit=5 → count 0,1,2,3,4,5 on successive cycles; t_en=4'b0011 when count=1 and 4'b0111 when count=3; done=1 for one cycle while count=5; then IDLE.
- Down with pause: start with dir=1, limit=4; pause=1 for 2 cycles when count=2 → count 4,3,2,2,2,1,0; t_en=0 during the pause; done 2 cycles later than the un-paused run.
- Boundaries: limit=0 → done after 1 RUN cycle with count=0. Up with limit=15 (WIDTH=4) → ends at 15 with no wrap; t_en=4'b1111 at count=7.
- Restart and ignore: start in DONE with limit=2, dir=0 → count reloads to 0 and runs to 2 with no IDLE cycle. Changing limit/dir mid-RUN has no effect.
- Abort: rst=0 when count=3 during an up run to 9 → next cycle count=0, IDLE, and done never pulses.
